msg_decrypt_engine: RTL and testbench
=====================================

MSG_DECRYPT_ENGINE -- requirements
Module: msg_decrypt_engine

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have start, input, 1, a one-cycle request to begin decryption, sampled only in IDLE.
REQ-004 SHALL have mem_addr, output, 8, the data memory address.
REQ-005 SHALL have mem_wr_en, output, 1, the data memory write strobe.
REQ-006 SHALL have mem_wdata, output, 8, the data memory write data.
REQ-007 SHALL have mem_rdata, input, 8, read data, valid the cycle after mem_addr is driven (registered memory).
REQ-008 SHALL have done, output, 1, high when a run has finished; held until the next accepted start or rst.
REQ-009 SHALL have fail, output, 1, high with done when no tap pattern matches the preamble.
REQ-010 SHALL have pt_no, output, 4, the index (0-8) of the detected tap pattern.
REQ-011 SHALL have pre_len, output, 7, the number of leading decrypted 0x20 bytes stripped (0-64).
REQ-012 SHALL have parity_errs, output, 7, the count of ciphertext bytes whose parity failed.

Function
REQ-013 Ciphertext SHALL be read from addresses 64-127; plaintext SHALL be written to addresses 0-63; no other address SHALL be written.
REQ-014 Tap table SHALL hold 9 entries, index 0-8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
REQ-015 LFSR step SHALL be next = {s[5:0], ^(s & tap)}, 7 bits.
REQ-016 The states SHALL be IDLE -> LOAD -> SEARCH -> DECODE -> PAD -> DONE; DONE SHALL go to LOAD on start; fail SHALL go from SEARCH directly to DONE.
REQ-017 LOAD SHALL read addresses 64-73 into a 10x7-bit buffer and set seed = buf[0] ^ 7'h20.
REQ-018 SEARCH SHALL try tap index k = 0..8 in order.
REQ-019 For each k, SEARCH SHALL step the LFSR from seed and check buf[i] ^ lfsr[i] == 0x20 for i = 1..9, one check per cycle.
REQ-020 SEARCH SHALL move to the next k on the first mismatch, and the lowest matching k SHALL win.
REQ-021 If no k matches, SEARCH SHALL set fail=1 and done=1 and perform no memory writes.
REQ-022 DECODE SHALL, for i = 0..63, read address 64+i, form p = rdata[6:0] ^ lfsr[i] and step the LFSR.
REQ-023 While all prior p equal 0x20 and p == 0x20, DECODE SHALL increment pre_len and SHALL NOT write.
REQ-024 Otherwise DECODE SHALL write {1'b0, p} to address wptr and increment wptr from 0.
REQ-025 Leading message spaces SHALL be absorbed into pre_len.
REQ-026 PAD SHALL write 0x20 to addresses wptr..63; PAD SHALL be skipped if wptr == 64.
REQ-027 If all 64 decrypted bytes are spaces, pre_len SHALL be 64 and PAD SHALL fill 0-63.
REQ-028 mem_wr_en SHALL be high for exactly one cycle per written byte and SHALL never be high in IDLE or DONE.
REQ-029 start while not in IDLE or DONE SHALL be ignored.
REQ-030 An accepted start SHALL clear done, fail, pre_len and parity_errs in the same edge.
REQ-031 Total run latency from start to done SHALL NOT exceed 400 cycles.

Reset
REQ-032 On rst (asynchronous, active-high), state SHALL be IDLE and all outputs 0: mem_addr, mem_wr_en, mem_wdata, done, fail, pt_no, pre_len and parity_errs.
REQ-033 rst mid-run SHALL abort immediately; the partial memory contents left behind are don't-care.
REQ-034 The first start after rst deassertion SHALL be accepted.

Configuration
REQ-035 With macro MSG_DEC_PARITY_CHECK_EN defined, DECODE SHALL count bytes where rdata[7] != ^rdata[6:0] into parity_errs, saturating at 127.
REQ-036 With MSG_DEC_PARITY_CHECK_EN defined, a byte that fails parity and is written SHALL be written as 0x3F ('?').
REQ-037 Without MSG_DEC_PARITY_CHECK_EN, bit 7 SHALL be ignored, parity_errs SHALL be tied 0, and p SHALL always be written.

Verification
REQ-038 Scenario 1: "Mr. Watson, come here. I want to see you." encrypted with pre_len 10, tap 0x60, seed 0x01 (byte 64 = 0x21), then start -> done=1, fail=0, pt_no=0, pre_len=10, addresses 0-40 = message, 41-63 = 0x20.
REQ-039 Scenario 2: loop all 9 taps x seeds {0x01, 0x55, 0x7F}, pre_len 15 -> pt_no equals the generating index each run and plaintext matches.
REQ-040 Scenario 3: ciphertext 0x00 at addresses 64-127 -> fail=1, done=1, pre_len=0, zero write strobes observed.
REQ-041 Scenario 4 (macro on): flip bit 7 of byte at address 80 -> parity_errs=1 and the corresponding output byte = 0x3F; macro off -> parity_errs=0 and the byte is correct.
REQ-042 Scenario 5: assert rst during DECODE, then start -> all outputs 0 at reset and the second run gives correct results.
REQ-043 Scenario 6: pulse start again mid-SEARCH -> no restart, and the result is identical to an undisturbed run.

Source files
------------

// File: rtl/msg_decrypt_engine.sv
// msg_decrypt_engine: recovers an LFSR-scrambled message held in data memory.
// Ciphertext at 64-127 is decoded, leading spaces are stripped into pre_len,
// and the plaintext plus space padding is written back to addresses 0-63.
// Optional feature macro: MSG_DEC_PARITY_CHECK_EN (bit 7 of each ciphertext
// byte is checked as parity; failing bytes are counted and written as '?').
module msg_decrypt_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       done,
  output logic       fail,
  output logic [3:0] pt_no,
  output logic [6:0] pre_len,
  output logic [6:0] parity_errs
);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECODE, PAD, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [6:0]  r_buf [0:9];
  logic [3:0]  r_cnt;
  logic [3:0]  r_k;
  logic [3:0]  r_i;
  logic [6:0]  r_lfsr;
  logic [5:0]  r_byte;
  logic [1:0]  r_phase;
  logic [6:0]  r_wptr;
  logic        r_allSp;
  logic [7:0]  r_addr;
  logic        r_wrEn;
  logic [7:0]  r_wdata;
  logic        r_done;
  logic        r_fail;
  logic [3:0]  r_ptNo;
  logic [6:0]  r_preLen;
  logic [6:0]  r_parityErrs;

  logic [6:0]  w_seed;
  logic [6:0]  w_tap;
  logic [6:0]  w_step;
  logic        w_match;
  logic [6:0]  w_p;
  logic        w_isSpace;
  logic        w_parityBad;

  // Tap polynomial table indexed by pattern number
  function automatic logic [6:0] tapOf(input logic [3:0] k);
    case (k)
      4'd0:    tapOf = 7'h60;
      4'd1:    tapOf = 7'h48;
      4'd2:    tapOf = 7'h78;
      4'd3:    tapOf = 7'h72;
      4'd4:    tapOf = 7'h6A;
      4'd5:    tapOf = 7'h69;
      4'd6:    tapOf = 7'h5C;
      4'd7:    tapOf = 7'h7E;
      4'd8:    tapOf = 7'h7B;
      default: tapOf = 7'h00;
    endcase
  endfunction

  // The first ciphertext byte always hides a space, so it reveals the seed
  assign w_seed    = r_buf[0] ^ 7'h20;
  assign w_tap     = tapOf(r_k);
  assign w_step    = {r_lfsr[5:0], ^(r_lfsr & w_tap)};
  assign w_match   = ((r_buf[r_i] ^ w_step) == 7'h20);
  assign w_p       = mem_rdata[6:0] ^ r_lfsr;
  assign w_isSpace = (w_p == 7'h20);

`ifdef MSG_DEC_PARITY_CHECK_EN
  assign w_parityBad = (mem_rdata[7] != ^mem_rdata[6:0]);
`else
  logic w_unusedParityBit;
  assign w_unusedParityBit = mem_rdata[7];
  assign w_parityBad       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state selection; start is only honoured in IDLE and DONE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = LOAD;
      LOAD:    if (r_cnt == 4'd11) w_nextState = SEARCH;
      SEARCH: begin
        if (w_match && (r_i == 4'd9))     w_nextState = DECODE;
        else if (!w_match && (r_k == 4'd8)) w_nextState = DONE;
      end
      DECODE:  if ((r_phase == 2'd2) && (r_byte == 6'd63)) w_nextState = PAD;
      PAD:     if (r_wptr[6]) w_nextState = DONE;
      DONE:    if (start) w_nextState = LOAD;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: preamble load, tap search, decode/write-back and padding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 10; j++) r_buf[j] <= 7'd0;
      r_cnt        <= 4'd0;
      r_k          <= 4'd0;
      r_i          <= 4'd1;
      r_lfsr       <= 7'd0;
      r_byte       <= 6'd0;
      r_phase      <= 2'd0;
      r_wptr       <= 7'd0;
      r_allSp      <= 1'b0;
      r_addr       <= 8'd0;
      r_wrEn       <= 1'b0;
      r_wdata      <= 8'd0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_ptNo       <= 4'd0;
      r_preLen     <= 7'd0;
      r_parityErrs <= 7'd0;
    end else begin
      r_wrEn <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_ptNo       <= 4'd0;
            r_preLen     <= 7'd0;
            r_parityErrs <= 7'd0;
            r_cnt        <= 4'd0;
          end
        end
        LOAD: begin
          // Read addresses are issued two cycles ahead of their data
          if (r_cnt < 4'd10) r_addr <= 8'd64 + {4'd0, r_cnt};
          if (r_cnt >= 4'd2) r_buf[r_cnt - 4'd2] <= mem_rdata[6:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd11) begin
            r_k    <= 4'd0;
            r_i    <= 4'd1;
            r_lfsr <= w_seed;
          end
        end
        SEARCH: begin
          if (w_match) begin
            if (r_i == 4'd9) begin
              r_ptNo  <= r_k;
              r_lfsr  <= w_seed;
              r_byte  <= 6'd0;
              r_phase <= 2'd0;
              r_wptr  <= 7'd0;
              r_allSp <= 1'b1;
            end else begin
              r_lfsr <= w_step;
              r_i    <= r_i + 4'd1;
            end
          end else if (r_k == 4'd8) begin
            r_fail <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_k    <= r_k + 4'd1;
            r_i    <= 4'd1;
            r_lfsr <= w_seed;
          end
        end
        DECODE: begin
          case (r_phase)
            2'd0: begin
              r_addr  <= {2'b01, r_byte};
              r_phase <= 2'd1;
            end
            2'd1: r_phase <= 2'd2;
            default: begin
              r_lfsr <= w_step;
              if (r_allSp && w_isSpace) begin
                r_preLen <= r_preLen + 7'd1;
              end else begin
                r_allSp <= 1'b0;
                r_addr  <= {1'b0, r_wptr};
                r_wrEn  <= 1'b1;
                r_wdata <= w_parityBad ? 8'h3F : {1'b0, w_p};
                r_wptr  <= r_wptr + 7'd1;
              end
`ifdef MSG_DEC_PARITY_CHECK_EN
              if (w_parityBad && (r_parityErrs != 7'h7F))
                r_parityErrs <= r_parityErrs + 7'd1;
`endif
              r_phase <= 2'd0;
              r_byte  <= r_byte + 6'd1;
            end
          endcase
        end
        PAD: begin
          // One idle cycle after the last write keeps the strobe out of DONE
          if (r_wptr[6]) begin
            r_done <= 1'b1;
          end else begin
            r_addr  <= {1'b0, r_wptr};
            r_wrEn  <= 1'b1;
            r_wdata <= 8'h20;
            r_wptr  <= r_wptr + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_addr;
  assign mem_wr_en   = r_wrEn;
  assign mem_wdata   = r_wdata;
  assign done        = r_done;
  assign fail        = r_fail;
  assign pt_no       = r_ptNo;
  assign pre_len     = r_preLen;
  assign parity_errs = r_parityErrs;

endmodule

// File: tb/tb_msg_decrypt_engine.sv
// Testbench for msg_decrypt_engine: a registered memory model, an encryptor
// that builds ciphertext images, and a reference decoder for expected results.
module tb_msg_decrypt_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] memAddr;
  logic       memWrEn;
  logic [7:0] memWdata;
  logic [7:0] memRdata;
  logic       done;
  logic       fail;
  logic [3:0] ptNo;
  logic [6:0] preLen;
  logic [6:0] parityErrs;

  int vecApplied = 0;
  int miscompares = 0;

  logic [7:0] mem [0:255];
  logic [7:0] imgCipher [0:63];
  logic       loadReq;
  int         writeCount;
  int         highWrites;

  logic [6:0] tapTab [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  string      msgText = "Mr. Watson, come here. I want to see you.";

  logic       expFail;
  int         expPt;
  int         expPre;
  int         expPar;
  logic [7:0] expImg [0:63];

  typedef struct {
    int         tapIdx;
    logic [6:0] seed;
    int         preLenIn;
    int         msgSel;
    int         flipAddr;
    int         expPreHand;
    int         expFailHand;
  } vec_t;

  vec_t vecs[$];

  msg_decrypt_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(memAddr), .mem_wr_en(memWrEn), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .done(done), .fail(fail), .pt_no(ptNo),
    .pre_len(preLen), .parity_errs(parityErrs)
  );

  always #5 clk = ~clk;

  // Registered single-port memory with a bulk-load hook for the bench
  always @(posedge clk) begin
    if (loadReq) begin
      for (int a = 0; a < 64; a++) begin
        mem[a]      <= 8'hAA;
        mem[64 + a] <= imgCipher[a];
      end
      writeCount <= 0;
      highWrites <= 0;
    end else if (memWrEn) begin
      mem[memAddr] <= memWdata;
      writeCount   <= writeCount + 1;
      if (memAddr >= 8'd64) highWrites <= highWrites + 1;
    end
    memRdata <= mem[memAddr];
  end

  function automatic logic [6:0] stepM(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decoder: lowest-matching tap search, then strip/write/pad
  task automatic computeExpected();
    logic [6:0] seed, s, p, c;
    logic       ok, allSp, bad;
    int         w;
    seed = imgCipher[0][6:0] ^ 7'h20;
    expFail = 1'b1;
    expPt = 0;
    expPre = 0;
    expPar = 0;
    for (int k = 0; k < 9 && expFail; k++) begin
      s = seed;
      ok = 1'b1;
      for (int i = 1; i < 10 && ok; i++) begin
        s = stepM(s, tapTab[k]);
        if ((imgCipher[i][6:0] ^ s) != 7'h20) ok = 1'b0;
      end
      if (ok) begin
        expFail = 1'b0;
        expPt = k;
      end
    end
    for (int i = 0; i < 64; i++) expImg[i] = 8'hAA;
    if (!expFail) begin
      s = seed;
      allSp = 1'b1;
      w = 0;
      for (int i = 0; i < 64; i++) begin
        c = imgCipher[i][6:0];
        p = c ^ s;
        s = stepM(s, tapTab[expPt]);
`ifdef MSG_DEC_PARITY_CHECK_EN
        bad = (imgCipher[i][7] != ^c);
`else
        bad = 1'b0;
`endif
        if (bad && expPar < 127) expPar++;
        if (allSp && p == 7'h20) begin
          expPre++;
        end else begin
          allSp = 1'b0;
          expImg[w] = bad ? 8'h3F : {1'b0, p};
          w++;
        end
      end
      for (int i = w; i < 64; i++) expImg[i] = 8'h20;
    end
  endtask

  // Build ciphertext for one vector, derive expectations, load the memory
  task automatic applyStimulus(input vec_t v);
    logic [6:0] plain [0:63];
    logic [6:0] s, c;
    for (int i = 0; i < 64; i++) plain[i] = 7'h20;
    if (v.msgSel == 0)
      for (int i = 0; i < msgText.len() && v.preLenIn + i < 64; i++)
        plain[v.preLenIn + i] = msgText[i][6:0];
    s = v.seed;
    for (int i = 0; i < 64; i++) begin
      c = plain[i] ^ s;
      imgCipher[i] = (v.msgSel == 2) ? 8'h00 : {^c, c};
      s = stepM(s, tapTab[v.tapIdx]);
    end
    if (v.flipAddr >= 64) imgCipher[v.flipAddr - 64][7] = ~imgCipher[v.flipAddr - 64][7];
    computeExpected();
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
  endtask

  // Start a run, optionally re-pulse start at cycle pulseAt, wait for done
  task automatic runOnce(input int pulseAt, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 450) begin
      start = (lat == pulseAt);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput("latencyWithin400", {63'd0, lat <= 400}, 64'd1);
  endtask

  task automatic checkResults(input vec_t v);
    int bad;
    checkOutput("done", {63'd0, done}, 64'd1);
    checkOutput("fail", {63'd0, fail}, {63'd0, expFail});
    if (!expFail) checkOutput("ptNo", {60'd0, ptNo}, expPt);
    checkOutput("preLen", {57'd0, preLen}, expPre);
    checkOutput("parityErrs", {57'd0, parityErrs}, expPar);
    checkOutput("writeStrobes", writeCount, expFail ? 0 : 64);
    checkOutput("cipherAreaWrites", highWrites, 0);
    checkOutput("wrEnInDone", {63'd0, memWrEn}, 64'd0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== expImg[i]) bad++;
    checkOutput("plaintextBytesWrong", bad, 0);
    if (v.expPreHand >= 0) checkOutput("preLenHand", {57'd0, preLen}, v.expPreHand);
    checkOutput("failHand", {63'd0, fail}, v.expFailHand);
    // Tap 0 cannot be pre-empted by a lower tap, so the message is known exactly
    if (v.msgSel == 0 && v.tapIdx == 0) begin
      logic [7:0] want;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        want = (i < msgText.len()) ? msgText[i] : 8'h20;
`ifdef MSG_DEC_PARITY_CHECK_EN
        if (v.flipAddr >= 64 && i == v.flipAddr - 64 - v.preLenIn) want = 8'h3F;
`endif
        if (mem[i] !== want) bad++;
      end
      checkOutput("messageBytesWrong", bad, 0);
      checkOutput("ptNoHand", {60'd0, ptNo}, 64'd0);
    end
  endtask

  initial begin
    int   lat0;
    int   lat1;
    vec_t v;
    rst = 1'b1;
    start = 1'b0;
    loadReq = 1'b0;
    vecs.push_back('{0, 7'h01, 10, 0, -1, 10, 0});
    foreach (tapTab[k]) begin
      vecs.push_back('{k, 7'h01, 15, 0, -1, -1, 0});
      vecs.push_back('{k, 7'h55, 15, 0, -1, -1, 0});
      vecs.push_back('{k, 7'h7F, 15, 0, -1, -1, 0});
    end
    vecs.push_back('{0, 7'h00, 0, 2, -1, 0, 1});
    vecs.push_back('{0, 7'h2A, 64, 1, -1, 64, 0});
    vecs.push_back('{0, 7'h01, 10, 0, 80, 10, 0});

    repeat (2) @(negedge clk);
    checkOutput("resetOutputs", {memAddr, memWrEn, memWdata, done, fail, ptNo, preLen, parityErrs}, 64'd0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      runOnce(-1, lat0);
      checkResults(vecs[n]);
    end

    // Reset in the middle of DECODE, then a clean rerun
    v = vecs[0];
    applyStimulus(v);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("midRunResetOutputs", {memAddr, memWrEn, memWdata, done, fail, ptNo, preLen, parityErrs}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(v);
    runOnce(-1, lat0);
    checkResults(v);

    // Extra start pulse during SEARCH must be ignored
    v = '{8, 7'h55, 15, 0, -1, -1, 0};
    applyStimulus(v);
    runOnce(-1, lat0);
    checkResults(v);
    applyStimulus(v);
    runOnce(14, lat1);
    checkResults(v);
    checkOutput("restartLatency", lat1, lat0);

    $display("== %0d vectors applied, %0d miscompares ==", vecApplied, miscompares);
    $finish;
  end

endmodule
